// File: rtl/arb_mux_nto1_reg.sv
// Registered CH-to-1 mux with valid/ready on every input and on the output.
// Selection is either explicit (mode=0, via sel) or round-robin (mode=1).
module arb_mux_nto1_reg #(
    parameter int N  = 64,
    parameter int CH = 8,
    localparam int SELW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    input  logic [CH*N-1:0] in_data,
    input  logic [CH-1:0]   in_valid,
    output logic [CH-1:0]   in_ready,
    output logic [N-1:0]    out_data,
    output logic [SELW-1:0] out_ch,
    output logic            out_valid,
    input  logic            out_ready
);

    // Handshake: a word moves on any port in a cycle where its valid and ready are both 1;
    // a producer holding valid must keep its data stable until it sees ready.

    logic [N-1:0]    out_data_q, out_data_d;
    logic [SELW-1:0] out_ch_q, out_ch_d;
    logic            out_valid_q, out_valid_d;
    logic [SELW-1:0] rr_ptr_q, rr_ptr_d;

    logic            load_en;
    logic [SELW-1:0] grant;
    logic            gvalid;
    logic            sel_valid;
    logic [SELW-1:0] rr_grant;
    logic            rr_found;
    logic [N-1:0]    grant_data;

    // Round-robin search: first pass from rr_ptr upward, second pass wraps from channel 0.
    always_comb begin
        sel_valid = 1'b0;
        rr_grant  = '0;
        rr_found  = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (sel == SELW'(i)) sel_valid = in_valid[i];
        end
        for (int i = 0; i < CH; i++) begin
            if (!rr_found && in_valid[i] && (SELW'(i) >= rr_ptr_q)) begin
                rr_found = 1'b1;
                rr_grant = SELW'(i);
            end
        end
        for (int i = 0; i < CH; i++) begin
            if (!rr_found && in_valid[i]) begin
                rr_found = 1'b1;
                rr_grant = SELW'(i);
            end
        end
    end

    always_comb begin
        grant      = mode ? rr_grant : sel;
        gvalid     = mode ? rr_found : sel_valid;
        load_en    = !out_valid_q || out_ready;
        grant_data = '0;
        for (int i = 0; i < CH; i++) begin
            if (grant == SELW'(i)) grant_data = in_data[i*N +: N];
        end
        for (int i = 0; i < CH; i++) begin
            in_ready[i] = !reset && load_en && gvalid && (grant == SELW'(i));
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en) begin
            if (gvalid) begin
                out_data_d  = grant_data;
                out_ch_d    = grant;
                out_valid_d = 1'b1;
                rr_ptr_d    = (grant == SELW'(CH - 1)) ? '0 : grant + SELW'(1);
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule
